// File: rtl/sort_sequencer_pkg.sv
// sort_sequencer_pkg
// Shared definitions for the bubble-sort sequencer: default widths, the
// compare direction and the controller state encoding.
// No ports; imported by sort_sequencer and sort_sequencer_ptr_ctr.

package sort_sequencer_pkg;

    // Default data word width and RAM address width
    localparam int DW_DEFAULT = 8;
    localparam int AW_DEFAULT = 4;

    // Compare convention: 1 sorts ascending (a later word smaller than the
    // earlier one is out of order); 0 would sort descending
    localparam bit SORT_ASC = 1'b1;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_CMP,
        S_WR0,
        S_WR1,
        S_DONE
    } state_e;

endpackage

// File: rtl/sort_sequencer_ptr_ctr.sv
// sort_sequencer_ptr_ctr
// Pointer counter pair for the bubble sort: j walks the compare position
// within a pass, lim is the last compare position of the current pass.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clr, lim_init   start a run: j=0, lim=lim_init
//   inc_j           advance to the next compare position
//   next_pass       start the next pass: j=0, lim shrinks by one
//   j, lim          current pointer values
//   j_at_lim        j has reached the last position of the pass
//   lim_zero        the current pass holds a single compare

module sort_sequencer_ptr_ctr
    import sort_sequencer_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [AW-1:0] lim_init,
    input  logic          inc_j,
    input  logic          next_pass,
    output logic [AW-1:0] j,
    output logic [AW-1:0] lim,
    output logic          j_at_lim,
    output logic          lim_zero
);

    logic [AW-1:0] j_q;
    logic [AW-1:0] lim_q;

    // clr wins over next_pass, which wins over inc_j; the controller never
    // asserts more than one of them in a cycle anyway
    always_ff @(posedge clk) begin
        if (rst) begin
            j_q   <= '0;
            lim_q <= '0;
        end else if (clr) begin
            j_q   <= '0;
            lim_q <= lim_init;
        end else if (next_pass) begin
            j_q   <= '0;
            lim_q <= lim_q - AW'(1);
        end else if (inc_j) begin
            j_q   <= j_q + AW'(1);
        end
    end

    assign j        = j_q;
    assign lim      = lim_q;
    assign j_at_lim = (j_q == lim_q);
    assign lim_zero = (lim_q == '0);

endmodule

// File: rtl/sort_sequencer.sv
// sort_sequencer
// Bubble-sorts len unsigned words in place in a single-port synchronous RAM
// (ascending, stable), stopping after the first pass without a swap.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, len      one-cycle request and element count (sampled in IDLE)
//   busy, done      high outside IDLE / one-cycle completion pulse
//   pass_cnt        passes executed in the last run
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata
//                   RAM interface, read data arrives one cycle after mem_rd

module sort_sequencer
    import sort_sequencer_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT,
    parameter int N  = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   pass_cnt,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic [DW-1:0] r0_q, r0_d;
    logic [DW-1:0] r1_q, r1_d;
    logic          swapped_q, swapped_d;
    logic [AW:0]   pass_cnt_q, pass_cnt_d;

    logic          ptrClr;
    logic          incJ;
    logic          nextPass;
    logic          endStep;
    logic          swapNow;
    logic [AW:0]   lenEff;
    logic [AW-1:0] limInit;
    logic [AW-1:0] j;
    logic [AW-1:0] lim;
    logic          jAtLim;
    logic          limZero;

    // Lengths above N are clamped; the last compare of the first pass sits
    // at index lenEff-2, which only matters when len >= 2
    assign lenEff  = (len > (AW+1)'(N)) ? (AW+1)'(N) : len;
    assign limInit = AW'(lenEff - (AW+1)'(2));

    // mem_rdata holds word j+1 in CMP and r0 holds word j; equal words are
    // left in place so the sort is stable
    assign swapNow = SORT_ASC ? (mem_rdata < r0_q) : (mem_rdata > r0_q);

    sort_sequencer_ptr_ctr #(
        .AW(AW)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ptrClr),
        .lim_init (limInit),
        .inc_j    (incJ),
        .next_pass(nextPass),
        .j        (j),
        .lim      (lim),
        .j_at_lim (jAtLim),
        .lim_zero (limZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            r0_q       <= '0;
            r1_q       <= '0;
            swapped_q  <= 1'b0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            swapped_q  <= swapped_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    // Next state, RAM strobes and pointer commands. The end-of-step decision
    // is shared by CMP (no swap) and WR1; in WR1 swapped_q is already set by
    // WR0, so "no swap this pass" is simply !swapped_q in both cases.
    always_comb begin
        state_d    = state_q;
        r0_d       = r0_q;
        r1_d       = r1_q;
        swapped_d  = swapped_q;
        pass_cnt_d = pass_cnt_q;
        ptrClr     = 1'b0;
        incJ       = 1'b0;
        nextPass   = 1'b0;
        endStep    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        mem_addr   = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (len < (AW+1)'(2)) begin
                        pass_cnt_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        ptrClr     = 1'b1;
                        swapped_d  = 1'b0;
                        pass_cnt_d = (AW+1)'(1);
                        state_d    = S_RD0;
                    end
                end
            end
            S_RD0: begin
                mem_addr = j;
                mem_rd   = 1'b1;
                state_d  = S_RD1;
            end
            S_RD1: begin
                mem_addr = j + AW'(1);
                mem_rd   = 1'b1;
                r0_d     = mem_rdata;
                state_d  = S_CMP;
            end
            S_CMP: begin
                r1_d = mem_rdata;
                if (swapNow) begin
                    state_d = S_WR0;
                end else begin
                    endStep = 1'b1;
                end
            end
            S_WR0: begin
                mem_addr  = j;
                mem_wdata = r1_q;
                mem_wr    = 1'b1;
                swapped_d = 1'b1;
                state_d   = S_WR1;
            end
            S_WR1: begin
                mem_addr  = j + AW'(1);
                mem_wdata = r0_q;
                mem_wr    = 1'b1;
                endStep   = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (endStep) begin
            if (!jAtLim) begin
                incJ    = 1'b1;
                state_d = S_RD0;
            end else if (limZero || !swapped_q) begin
                state_d = S_DONE;
            end else begin
                nextPass   = 1'b1;
                swapped_d  = 1'b0;
                pass_cnt_d = pass_cnt_q + (AW+1)'(1);
                state_d    = S_RD0;
            end
        end
    end

    assign pass_cnt = pass_cnt_q;

endmodule
